ksa_controller: RTL and testbench

//  Sequences the full RC4 key-scheduling algorithm on the 256x8 single-port S RAM (ramcore).

---
 rtl/ksa_controller_if.sv | 42 ++++
 rtl/ksa_controller.sv | 163 ++++++++++++++++
 tb/tb_ksa_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ksa_controller_if.sv
// ksa_controller_if
//   Groups the KSA controller's run handshake and its ramcore port.
//   master : the controller. It drives the RAM address, data and write enable,
//            and reports busy and done.
//   slave  : the environment. It drives start and returns the RAM read data.
//   Signals:
//     start     run request, sampled by the controller only while idle
//     busy      a run is in progress
//     done      level; a run has completed and no new run has been accepted yet
//     ram_addr  ramcore address
//     ram_wdata ramcore write data
//     ram_wren  ramcore write enable
//     ram_rdata ramcore q; valid one cycle after the address is presented
interface ksa_controller_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_wren;
  logic [7:0] ram_rdata;

  modport master (
    input  start,
    input  ram_rdata,
    output busy,
    output done,
    output ram_addr,
    output ram_wdata,
    output ram_wren
  );

  modport slave (
    output start,
    output ram_rdata,
    input  busy,
    input  done,
    input  ram_addr,
    input  ram_wdata,
    input  ram_wren
  );
endinterface

// File: rtl/ksa_controller.sv
// ksa_controller
//   Runs the complete RC4 key-scheduling algorithm on a 256x8 single-port
//   S RAM. The first phase writes S[i] = i. The second phase, for each i,
//   computes j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] with S[j].
//   While busy, this block is the only master of the RAM port.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous, active-low reset
//     key    secret key; key byte 0 is the most significant byte.
//            It must be held stable while busy.
//     bus    handshake and ramcore port (master modport)
//            start/busy/done, ram_addr/ram_wdata/ram_wren, ram_rdata
module ksa_controller #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*KEY_BYTES-1:0] key,
  ksa_controller_if.master       bus
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, INIT, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ
  } state_t;

  state_t        state, state_n;
  logic [7:0]    i, i_n;
  logic [7:0]    j, j_n;
  logic [KW-1:0] k, k_n;
  logic [7:0]    si, si_n;
  logic [7:0]    sj, sj_n;
  logic [7:0]    addr_n, wdata_n;
  logic          wren_n, done_n;
  logic [7:0]    key_byte;

  // Key byte k is selected with a plain mux. k runs beside i and wraps at
  // KEY_BYTES, so no i mod KEY_BYTES divider is needed.
  function automatic logic [7:0] sel_key_byte(
    input logic [8*KEY_BYTES-1:0] kv,
    input logic [KW-1:0]          idx
  );
    logic [7:0] b;
    b = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (idx == KW'(n)) b = kv[8*(KEY_BYTES-1-n) +: 8];
    end
    return b;
  endfunction

  assign key_byte = sel_key_byte(key, k);
  assign bus.busy = (state != IDLE);

  // The RAM outputs are registered. The next-state logic therefore computes
  // the address, data and enable that the RAM must see during the next
  // state. The RAM samples that address at the end of the state, and the
  // read data comes back in the following state (WT_*).
  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    si_n    = si;
    sj_n    = sj;
    addr_n  = bus.ram_addr;
    wdata_n = bus.ram_wdata;
    wren_n  = 1'b0;
    done_n  = bus.done;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = INIT;
          i_n     = 8'd0;
          done_n  = 1'b0;
          addr_n  = 8'd0;
          wdata_n = 8'd0;
          wren_n  = 1'b1;
        end
      end
      INIT: begin
        if (i == 8'd255) begin
          state_n = RD_SI;
          i_n     = 8'd0;
          j_n     = 8'd0;
          k_n     = '0;
          addr_n  = 8'd0;
        end else begin
          i_n     = i + 8'd1;
          addr_n  = i + 8'd1;
          wdata_n = i + 8'd1;
          wren_n  = 1'b1;
        end
      end
      RD_SI: state_n = WT_SI;
      WT_SI: begin
        si_n    = bus.ram_rdata;
        j_n     = j + bus.ram_rdata + key_byte;
        addr_n  = j + bus.ram_rdata + key_byte;
        state_n = RD_SJ;
      end
      RD_SJ: state_n = WT_SJ;
      WT_SJ: begin
        sj_n    = bus.ram_rdata;
        addr_n  = i;
        wdata_n = bus.ram_rdata;
        wren_n  = 1'b1;
        state_n = WR_SI;
      end
      WR_SI: begin
        // When i == j, this second write lands on the same address with the
        // old S[i], which leaves the entry unchanged, as the algorithm requires.
        addr_n  = j;
        wdata_n = si;
        wren_n  = 1'b1;
        state_n = WR_SJ;
      end
      WR_SJ: begin
        if (i == 8'd255) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          i_n     = i + 8'd1;
          k_n     = (k == K_LAST) ? '0 : k + KW'(1);
          addr_n  = i + 8'd1;
          state_n = RD_SI;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      i             <= 8'd0;
      j             <= 8'd0;
      k             <= '0;
      bus.ram_addr  <= 8'd0;
      bus.ram_wdata <= 8'd0;
      bus.ram_wren  <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_n;
      i             <= i_n;
      j             <= j_n;
      k             <= k_n;
      bus.ram_addr  <= addr_n;
      bus.ram_wdata <= wdata_n;
      bus.ram_wren  <= wren_n;
      bus.done      <= done_n;
    end
  end

  // si and sj are always written in a WT_* state before they are used,
  // so they have no reset.
  always_ff @(posedge clk) begin
    si <= si_n;
    sj <= sj_n;
  end

endmodule

// File: tb/tb_ksa_controller.sv
module tb_ksa_controller;
  localparam int KB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] key = 24'h0;

  ksa_controller_if bus();

  ksa_controller #(.KEY_BYTES(KB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ramcore model: synchronous single port, 1-cycle read latency
  logic [7:0] mem [256];
  logic [7:0] q;
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
    q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = q;

  // write log and busy cycle counter
  int         wr_n = 0;
  int         busy_cnt = 0;
  logic [7:0] wr_a [16384];
  logic [7:0] wr_d [16384];
  always @(posedge clk) begin
    if (bus.ram_wren && wr_n < 16384) begin
      wr_a[wr_n] <= bus.ram_addr;
      wr_d[wr_n] <= bus.ram_wdata;
      wr_n       <= wr_n + 1;
    end
    if (bus.busy) busy_cnt <= busy_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // software RC4 KSA reference
  logic [7:0] exp_s [256];
  task automatic model(input logic [23:0] kv);
    logic [7:0] jj, t;
    for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + exp_s[n] + kv[8*(2-(n%3)) +: 8];
      t = exp_s[n];
      exp_s[n] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic start_run(input logic [23:0] kv, output int wb, output int bb);
    @(negedge clk);
    key = kv;
    bus.start = 1'b1;
    wb = wr_n;
    bb = busy_cnt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit pulses);
    int c;
    bit ok;
    c = 0;
    ok = 1'b0;
    while (!ok && c < 3000) begin
      if (bus.done) ok = 1'b1;
      else begin
        bus.start = (pulses && (c == 10 || c == 900)) ? 1'b1 : 1'b0;
        @(negedge clk);
        c++;
      end
    end
    bus.start = 1'b0;
    check("done_reached", 32'(ok), 32'd1);
  endtask

  task automatic verify_run(input string tag, input logic [23:0] kv, input int wb, input int bb);
    int bad;
    check({tag, "_busy_len"}, 32'(busy_cnt - bb), 32'd1792);
    check({tag, "_write_count"}, 32'(wr_n - wb), 32'd768);
    model(kv);
    bad = 0;
    for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) bad++;
    check({tag, "_s_mismatches"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [23:0] key;
    logic [7:0]  j0;
    logic [7:0]  j1;
  } vec_t;
  vec_t vecs [5];

  initial begin
    int wb, bb, bad;
    vecs[0] = '{key: 24'h000000, j0: 8'h00, j1: 8'h01};
    vecs[1] = '{key: 24'h0103FF, j0: 8'h01, j1: 8'h04};
    vecs[2] = '{key: 24'h00ABCD, j0: 8'h00, j1: 8'hAC};
    vecs[3] = '{key: 24'hFF0000, j0: 8'hFF, j1: 8'h00};
    vecs[4] = '{key: 24'h000249, j0: 8'h00, j1: 8'h03};

    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    check("rst_wren", 32'(bus.ram_wren), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      start_run(vecs[v].key, wb, bb);
      // first INIT cycle; done (high from the previous row) must have dropped
      check("first_init_busy", 32'(bus.busy), 32'd1);
      check("first_init_wren", 32'(bus.ram_wren), 32'd1);
      check("first_init_addr", 32'(bus.ram_addr), 32'd0);
      check("start_clears_done", 32'(bus.done), 32'd0);
      wait_done(1'b0);
      verify_run($sformatf("vec%0d", v), vecs[v].key, wb, bb);
      bad = 0;
      for (int n = 0; n < 256; n++)
        if (wr_a[wb+n] !== 8'(n) || wr_d[wb+n] !== 8'(n)) bad++;
      check("init_seq_bad", 32'(bad), 32'd0);
      check("swap0_wr1_addr", 32'(wr_a[wb+256]), 32'd0);
      check("swap0_wr1_data", 32'(wr_d[wb+256]), 32'(vecs[v].j0));
      check("swap0_wr2_addr", 32'(wr_a[wb+257]), 32'(vecs[v].j0));
      check("swap0_wr2_data", 32'(wr_d[wb+257]), 32'd0);
      check("swap1_wr1_addr", 32'(wr_a[wb+258]), 32'd1);
      check("swap1_wr2_addr", 32'(wr_a[wb+259]), 32'(vecs[v].j1));
      repeat (3) @(negedge clk);
      check("done_level", 32'(bus.done), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_wren", 32'(bus.ram_wren), 32'd0);
    end

    // start pulses while busy are ignored
    start_run(24'h000249, wb, bb);
    wait_done(1'b1);
    verify_run("t5", 24'h000249, wb, bb);

    // asynchronous reset during the swap phase
    start_run(24'h000249, wb, bb);
    repeat (1000) @(negedge clk);
    check("t6_busy_before_rst", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_wren", 32'(bus.ram_wren), 32'd0);
    check("t6_async_busy", 32'(bus.busy), 32'd0);
    check("t6_async_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_stays_idle", 32'(bus.busy), 32'd0);
    check("t6_no_done", 32'(bus.done), 32'd0);
    start_run(24'h000249, wb, bb);
    wait_done(1'b0);
    verify_run("t6_rerun", 24'h000249, wb, bb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
